cp0_exception_unit: RTL and testbench

CP0_EXCEPTION_UNIT -- requirements
Module: cp0_exception_unit

---
 rtl/cp0_exception_unit_pkg.sv | 53 +++++
 rtl/cp0_timer.sv | 39 +++
 rtl/cp0_exception_unit.sv | 146 ++++++++++++++
 tb/tb_cp0_exception_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exception_unit_pkg.sv
// rtl/cp0_exception_unit_pkg.sv - shared CP0 exception flags, codes, register numbers and vector
package cp0_exception_unit_pkg;

   // Exception flags carried by an instruction down the pipe, highest priority first
   typedef struct packed {
      logic Interrupt;
      logic WrongAddressinIF;
      logic ReservedInstruction;
      logic Overflow;
      logic Syscall;
      logic Break;
      logic Eret;
      logic RdWrongAddressinMEM;
      logic WrWrongAddressinMEM;
   } ExceptinPipeType;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;
   localparam logic [31:0] STATUS_RESET = 32'h00400000;

   // Any flag other than Eret means an exception is taken
   function automatic logic is_exception(input ExceptinPipeType e);
      return e.Interrupt | e.WrongAddressinIF | e.ReservedInstruction | e.Overflow |
             e.Syscall | e.Break | e.RdWrongAddressinMEM | e.WrWrongAddressinMEM;
   endfunction

   // Priority-encoded ExcCode of the winning flag
   function automatic logic [4:0] exc_code_of(input ExceptinPipeType e);
      if (e.Interrupt)                return EXC_INT;
      else if (e.WrongAddressinIF)    return EXC_ADEL;
      else if (e.ReservedInstruction) return EXC_RI;
      else if (e.Overflow)            return EXC_OV;
      else if (e.Syscall)             return EXC_SYS;
      else if (e.Break)               return EXC_BP;
      else if (e.RdWrongAddressinMEM) return EXC_ADEL;
      else                            return EXC_ADES;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count/Compare pair with timer interrupt flag
module cp0_timer
   import cp0_exception_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic [31:0] wr_data,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic toggle;

   // Count advances on every second edge; software writes win over the increment, Compare write clears TI
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         toggle  <= 1'b0;
         count   <= 32'd0;
         compare <= 32'd0;
         ti      <= 1'b0;
      end else begin
         toggle <= ~toggle;
         if (wr_count)
            count <= wr_data;
         else if (toggle)
            count <= count + 32'd1;
         if (wr_compare) begin
            compare <= wr_data;
            ti      <= 1'b0;
         end else if (count == compare) begin
            ti <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 status/cause/EPC/BadVAddr, exception select and redirect
module cp0_exception_unit
   import cp0_exception_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  ExceptinPipeType MEM_ExceptType,
   input  logic [31:0]     MEM_PC,
   input  logic            MEM_IsDelaySlot,
   input  logic [31:0]     MEM_ALUOut,
   input  logic            CP0Wr,
   input  logic [4:0]      CP0_WrAddr,
   input  logic [2:0]      CP0_WrSel,
   input  logic [31:0]     CP0_WrData,
   input  logic [4:0]      CP0_RdAddr,
   input  logic [2:0]      CP0_RdSel,
   output logic [31:0]     CP0_RdData,
   input  logic [5:0]      HW_Int,
   output logic            Int_Pending,
   output logic            Exc_Flush,
   output logic [31:0]     Exc_NPC
);

   logic [7:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [1:0]  ip_sw;
   logic [4:0]  exc_code;
   logic [31:0] epc;
   logic [31:0] badvaddr;

   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;
   logic [7:0]  ip;
   logic [31:0] status_val;
   logic [31:0] cause_val;

   logic        exc_take;
   logic        eret_take;
   logic [4:0]  code_next;
   logic        bad_load;
   logic [31:0] bad_next;

   logic wr_sel0;
   logic wr_status;
   logic wr_cause;
   logic wr_epc;

   assign wr_sel0   = CP0Wr && (CP0_WrSel == 3'd0);
   assign wr_status = wr_sel0 && (CP0_WrAddr == CP0_STATUS);
   assign wr_cause  = wr_sel0 && (CP0_WrAddr == CP0_CAUSE);
   assign wr_epc    = wr_sel0 && (CP0_WrAddr == CP0_EPC);

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .wr_count   (wr_sel0 && (CP0_WrAddr == CP0_COUNT)),
      .wr_compare (wr_sel0 && (CP0_WrAddr == CP0_COMPARE)),
      .wr_data    (CP0_WrData),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   assign ip         = {HW_Int[5] | ti, HW_Int[4:0], ip_sw};
   assign status_val = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
   assign cause_val  = {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};

   assign Int_Pending = ie & ~exl & (|(ip & im));

   // Exception/Eret decision, redirect target and BadVAddr source from the winning flag
   always_comb begin
      exc_take  = is_exception(MEM_ExceptType);
      eret_take = MEM_ExceptType.Eret & ~exc_take;
      code_next = exc_code_of(MEM_ExceptType);
      bad_load  = 1'b0;
      bad_next  = MEM_ALUOut;
      if (!MEM_ExceptType.Interrupt) begin
         if (MEM_ExceptType.WrongAddressinIF) begin
            bad_load = 1'b1;
            bad_next = MEM_PC;
         end else if (!MEM_ExceptType.ReservedInstruction && !MEM_ExceptType.Overflow &&
                      !MEM_ExceptType.Syscall && !MEM_ExceptType.Break &&
                      (MEM_ExceptType.RdWrongAddressinMEM || MEM_ExceptType.WrWrongAddressinMEM)) begin
            bad_load = 1'b1;
         end
      end
      Exc_Flush = rst & (exc_take | eret_take);
      Exc_NPC   = eret_take ? epc : EXC_VECTOR;
   end

   // MFC0 read mux over current register state
   always_comb begin
      CP0_RdData = 32'd0;
      if (CP0_RdSel == 3'd0) begin
         case (CP0_RdAddr)
            CP0_BADVADDR: CP0_RdData = badvaddr;
            CP0_COUNT:    CP0_RdData = count;
            CP0_COMPARE:  CP0_RdData = compare;
            CP0_STATUS:   CP0_RdData = status_val;
            CP0_CAUSE:    CP0_RdData = cause_val;
            CP0_EPC:      CP0_RdData = epc;
            default:      CP0_RdData = 32'd0;
         endcase
      end
   end

   // MTC0 updates first, then exception/Eret updates override the affected fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         im       <= 8'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip_sw    <= 2'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
         badvaddr <= 32'd0;
      end else begin
         if (wr_status) begin
            im  <= CP0_WrData[15:8];
            exl <= CP0_WrData[1];
            ie  <= CP0_WrData[0];
         end
         if (wr_cause)
            ip_sw <= CP0_WrData[9:8];
         if (wr_epc)
            epc <= CP0_WrData;
         if (exc_take) begin
            exl      <= 1'b1;
            exc_code <= code_next;
            if (!exl) begin
               epc <= MEM_IsDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
               bd  <= MEM_IsDelaySlot;
            end
            if (bad_load)
               badvaddr <= bad_next;
         end else if (eret_take) begin
            exl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - directed scoreboard bench for cp0_exception_unit
module tb_cp0_exception_unit;
   import cp0_exception_unit_pkg::*;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   ExceptinPipeType MEM_ExceptType;
   logic [31:0]     MEM_PC;
   logic            MEM_IsDelaySlot;
   logic [31:0]     MEM_ALUOut;
   logic            CP0Wr;
   logic [4:0]      CP0_WrAddr;
   logic [2:0]      CP0_WrSel;
   logic [31:0]     CP0_WrData;
   logic [4:0]      CP0_RdAddr;
   logic [2:0]      CP0_RdSel;
   logic [31:0]     CP0_RdData;
   logic [5:0]      HW_Int;
   logic            Int_Pending;
   logic            Exc_Flush;
   logic [31:0]     Exc_NPC;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   cp0_exception_unit dut (
      .clk             (clk),
      .rst             (rst),
      .MEM_ExceptType  (MEM_ExceptType),
      .MEM_PC          (MEM_PC),
      .MEM_IsDelaySlot (MEM_IsDelaySlot),
      .MEM_ALUOut      (MEM_ALUOut),
      .CP0Wr           (CP0Wr),
      .CP0_WrAddr      (CP0_WrAddr),
      .CP0_WrSel       (CP0_WrSel),
      .CP0_WrData      (CP0_WrData),
      .CP0_RdAddr      (CP0_RdAddr),
      .CP0_RdSel       (CP0_RdSel),
      .CP0_RdData      (CP0_RdData),
      .HW_Int          (HW_Int),
      .Int_Pending     (Int_Pending),
      .Exc_Flush       (Exc_Flush),
      .Exc_NPC         (Exc_NPC)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      e = sb.pop_front();
      vectors++;
      assert (obs === e.val) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_field(input string tag, input logic [4:0] addr, input int sh,
                            input logic [31:0] mask, input logic [31:0] exp);
      push_exp(tag, exp);
      CP0_RdAddr = addr;
      CP0_RdSel  = 3'd0;
      #1;
      check((CP0_RdData >> sh) & mask);
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      chk_field(tag, addr, 0, 32'hFFFFFFFF, exp);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      push_exp(tag, exp);
      check(obs);
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      CP0Wr      = 1'b1;
      CP0_WrAddr = addr;
      CP0_WrSel  = 3'd0;
      CP0_WrData = data;
      tick();
      CP0Wr = 1'b0;
   endtask

   task automatic clear_flags();
      MEM_ExceptType  = '0;
      MEM_IsDelaySlot = 1'b0;
   endtask

   // Present one flag set, check the combinational redirect, then let it retire
   task automatic raise(input ExceptinPipeType f, input logic [31:0] npc, input string tag);
      MEM_ExceptType = f;
      #1;
      chk_out({tag, "_flush"}, {31'd0, Exc_Flush}, 32'd1);
      chk_out({tag, "_npc"}, Exc_NPC, npc);
      tick();
      clear_flags();
   endtask

   initial begin
      ExceptinPipeType f;
      bit ti_seen;

      clear_flags();
      MEM_PC     = 32'd0;
      MEM_ALUOut = 32'd0;
      CP0Wr      = 1'b0;
      CP0_WrAddr = 5'd0;
      CP0_WrSel  = 3'd0;
      CP0_WrData = 32'd0;
      CP0_RdAddr = 5'd0;
      CP0_RdSel  = 3'd0;
      HW_Int     = 6'd0;

      #12;
      chk_reg("rst_status", CP0_STATUS, 32'h00400000);
      chk_reg("rst_cause", CP0_CAUSE, 32'd0);
      chk_reg("rst_epc", CP0_EPC, 32'd0);
      chk_reg("rst_badvaddr", CP0_BADVADDR, 32'd0);
      chk_reg("rst_count", CP0_COUNT, 32'd0);
      chk_reg("rst_compare", CP0_COMPARE, 32'd0);
      chk_out("rst_flush", {31'd0, Exc_Flush}, 32'd0);
      chk_out("rst_intp", {31'd0, Int_Pending}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk_out("idle_flush", {31'd0, Exc_Flush}, 32'd0);

      // Overflow, not in a delay slot
      MEM_PC = 32'hBFC00100;
      f = '0; f.Overflow = 1'b1;
      raise(f, EXC_VECTOR, "ov");
      chk_reg("ov_epc", CP0_EPC, 32'hBFC00100);
      chk_field("ov_code", CP0_CAUSE, 2, 32'h1F, 32'h0C);
      chk_field("ov_exl", CP0_STATUS, 1, 32'h1, 32'h1);
      f = '0; f.Eret = 1'b1;
      raise(f, 32'hBFC00100, "eret1");
      chk_field("eret1_exl", CP0_STATUS, 1, 32'h1, 32'h0);

      // Syscall in a delay slot, then Eret back
      MEM_PC = 32'hBFC00204;
      MEM_IsDelaySlot = 1'b1;
      f = '0; f.Syscall = 1'b1;
      raise(f, EXC_VECTOR, "sys");
      chk_reg("sys_epc", CP0_EPC, 32'hBFC00200);
      chk_field("sys_bd", CP0_CAUSE, 31, 32'h1, 32'h1);
      chk_field("sys_code", CP0_CAUSE, 2, 32'h1F, 32'h08);
      f = '0; f.Eret = 1'b1;
      raise(f, 32'hBFC00200, "eret2");
      chk_field("eret2_exl", CP0_STATUS, 1, 32'h1, 32'h0);

      // Load address error in MEM
      MEM_PC = 32'hBFC00300;
      MEM_ALUOut = 32'h80000003;
      f = '0; f.RdWrongAddressinMEM = 1'b1;
      raise(f, EXC_VECTOR, "adel");
      chk_reg("adel_bad", CP0_BADVADDR, 32'h80000003);
      chk_field("adel_code", CP0_CAUSE, 2, 32'h1F, 32'h04);
      chk_reg("adel_epc", CP0_EPC, 32'hBFC00300);
      chk_field("adel_bd", CP0_CAUSE, 31, 32'h1, 32'h0);

      // Nested exception while EXL=1: interrupt wins, EPC and BadVAddr untouched
      MEM_PC = 32'h11111110;
      MEM_ALUOut = 32'h00000022;
      MEM_IsDelaySlot = 1'b1;
      f = '0; f.Interrupt = 1'b1; f.Overflow = 1'b1; f.WrWrongAddressinMEM = 1'b1;
      raise(f, EXC_VECTOR, "prio");
      chk_field("prio_code", CP0_CAUSE, 2, 32'h1F, 32'h00);
      chk_reg("prio_epc", CP0_EPC, 32'hBFC00300);
      chk_reg("prio_bad", CP0_BADVADDR, 32'h80000003);
      chk_field("prio_bd", CP0_CAUSE, 31, 32'h1, 32'h0);

      // Eret together with another flag is an exception
      f = '0; f.Eret = 1'b1; f.Overflow = 1'b1;
      raise(f, EXC_VECTOR, "eretov");
      chk_field("eretov_code", CP0_CAUSE, 2, 32'h1F, 32'h0C);
      chk_field("eretov_exl", CP0_STATUS, 1, 32'h1, 32'h1);

      MEM_PC = 32'hBFC00123;
      f = '0; f.WrongAddressinIF = 1'b1; f.RdWrongAddressinMEM = 1'b1;
      raise(f, EXC_VECTOR, "if");
      chk_reg("if_bad", CP0_BADVADDR, 32'hBFC00123);
      chk_field("if_code", CP0_CAUSE, 2, 32'h1F, 32'h04);
      MEM_ALUOut = 32'h00000044;
      f = '0; f.WrWrongAddressinMEM = 1'b1;
      raise(f, EXC_VECTOR, "ades");
      chk_reg("ades_bad", CP0_BADVADDR, 32'h00000044);
      chk_field("ades_code", CP0_CAUSE, 2, 32'h1F, 32'h05);
      f = '0; f.Break = 1'b1; f.ReservedInstruction = 1'b1;
      raise(f, EXC_VECTOR, "ri");
      chk_field("ri_code", CP0_CAUSE, 2, 32'h1F, 32'h0A);
      f = '0; f.Eret = 1'b1;
      raise(f, 32'hBFC00300, "eret3");

      // MTC0 alone never flushes; EPC write feeds Eret; unmapped reads as zero
      CP0Wr = 1'b1; CP0_WrAddr = CP0_EPC; CP0_WrData = 32'h12345670;
      #1;
      chk_out("mtc0_flush", {31'd0, Exc_Flush}, 32'd0);
      tick();
      CP0Wr = 1'b0;
      chk_reg("epc_wr", CP0_EPC, 32'h12345670);
      mtc0(5'd5, 32'hDEADBEEF);
      chk_reg("unmapped", 5'd5, 32'd0);
      f = '0; f.Eret = 1'b1;
      raise(f, 32'h12345670, "eret4");

      // Timer: Count=0 then Compare=10, TI expected about 20 cycles later
      mtc0(CP0_COUNT, 32'd0);
      chk_field("cnt_zero", CP0_COUNT, 0, 32'hFFFFFFFE, 32'd0);
      mtc0(CP0_COMPARE, 32'd10);
      chk_reg("cmp_wr", CP0_COMPARE, 32'd10);
      for (int i = 0; i < 14; i++) tick();
      chk_field("ti_early", CP0_CAUSE, 30, 32'h1, 32'h0);
      ti_seen = 1'b0;
      CP0_RdAddr = CP0_CAUSE;
      for (int i = 0; i < 12 && !ti_seen; i++) begin
         tick();
         if (CP0_RdData[30]) ti_seen = 1'b1;
      end
      chk_out("ti_set", {31'd0, ti_seen}, 32'd1);
      chk_field("ti_ip7", CP0_CAUSE, 15, 32'h1, 32'h1);
      mtc0(CP0_STATUS, 32'h0000FF01);
      chk_reg("status_ff01", CP0_STATUS, 32'h0040FF01);
      chk_out("intp_ti", {31'd0, Int_Pending}, 32'd1);
      mtc0(CP0_COMPARE, 32'h00001000);
      chk_field("ti_clr", CP0_CAUSE, 30, 32'h1, 32'h0);
      chk_out("intp_clr", {31'd0, Int_Pending}, 32'd0);
      HW_Int = 6'b000001;
      #1;
      chk_out("intp_hw", {31'd0, Int_Pending}, 32'd1);
      chk_field("ip2_hw", CP0_CAUSE, 10, 32'h1, 32'h1);
      HW_Int = 6'd0;

      // MTC0 Status together with Break
      CP0Wr = 1'b1; CP0_WrAddr = CP0_STATUS; CP0_WrData = 32'h00000001;
      f = '0; f.Break = 1'b1;
      raise(f, EXC_VECTOR, "brk");
      CP0Wr = 1'b0;
      chk_reg("brk_status", CP0_STATUS, 32'h00400003);
      chk_field("brk_code", CP0_CAUSE, 2, 32'h1F, 32'h09);
      chk_out("brk_intp", {31'd0, Int_Pending}, 32'd0);

      // Count wrap
      mtc0(CP0_COUNT, 32'hFFFFFFFF);
      chk_reg("cnt_max", CP0_COUNT, 32'hFFFFFFFF);
      tick();
      tick();
      chk_reg("cnt_wrap", CP0_COUNT, 32'd0);

      // Reset in the middle of an exception
      MEM_PC = 32'hBFC00500;
      f = '0; f.Overflow = 1'b1;
      MEM_ExceptType = f;
      rst = 1'b0;
      #1;
      chk_out("mrst_flush", {31'd0, Exc_Flush}, 32'd0);
      chk_reg("mrst_status", CP0_STATUS, 32'h00400000);
      chk_reg("mrst_cause", CP0_CAUSE, 32'd0);
      chk_reg("mrst_epc", CP0_EPC, 32'd0);
      chk_reg("mrst_bad", CP0_BADVADDR, 32'd0);
      chk_reg("mrst_count", CP0_COUNT, 32'd0);
      chk_reg("mrst_compare", CP0_COMPARE, 32'd0);
      tick();
      chk_reg("mrst_epc_held", CP0_EPC, 32'd0);
      @(negedge clk);
      clear_flags();
      rst = 1'b1;
      tick();
      chk_reg("post_status", CP0_STATUS, 32'h00400000);
      chk_reg("post_epc", CP0_EPC, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
